// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the IF/LS memory port arbiter.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which requester a grant goes to
//   cnt_w()     : width of a counter that must hold 0..max_val
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LS_BUSY = 2'd2,
    IF_DROP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  localparam int DEF_MAX_LS_STREAK = 4;
  localparam int DEF_TIMEOUT       = 255;

  localparam int STREAK_W = $clog2(DEF_MAX_LS_STREAK + 1);
  localparam int TMR_W    = $clog2(DEF_TIMEOUT + 1);

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: up-counter cleared at each grant, advanced while a
// transaction is outstanding, flags expiry on the last allowed cycle.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : restart the count (new transaction granted)
//   i_en         : a transaction is outstanding this cycle
//   o_expire     : this is the LIMIT-th outstanding cycle without completion
module arb_watchdog
  import arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = cnt_w(LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count <= '0;
    end else if (i_en && count != CW'(LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of cycles already spent, so the current cycle is
  // the LIMIT-th one when count reads LIMIT-1.
  always_comb begin
    o_expire = i_en && (count == CW'(LIMIT - 1));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch (IF) and the load/store unit (LS). One transaction at a time, LS has
// priority bounded by a streak counter, flushed fetches are drained silently,
// and a watchdog aborts transactions the memory never acknowledges.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_if_*  / o_if_*        : fetch request, address, flush, data, done pulse
//   i_ls_*  / o_ls_*        : load/store request, we, addr, wdata, bmask, data, done
//   o_mem_* / i_mem_*       : memory request side, ack + read data
//   o_stall_if, o_stall_ls  : stall lines to the hazard unit
//   o_err                   : sticky timeout flag
//
// state   | meaning
// IDLE    | no transaction outstanding, arbitrate this cycle
// IF_BUSY | fetch outstanding, waiting for ack
// LS_BUSY | load/store outstanding, waiting for ack
// IF_DROP | flushed fetch still outstanding, wait for ack and discard
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = DEF_MAX_LS_STREAK,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_vld,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_bmask,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_ls_vld,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_stall_if,
  output logic                o_stall_ls,
  output logic                o_err
);

  localparam int SW = cnt_w(MAX_LS_STREAK);

  arb_state_e    state;
  logic [SW-1:0] streak;
  logic          if_elig;
  logic          ls_elig;
  logic          grant;
  arb_owner_e    grant_owner;
  logic          wd_expire;

  // The vld terms keep a requester that is just seeing its completion from
  // being granted again on its still-high request level.
  always_comb begin
    if_elig     = i_if_req & ~i_if_flush & ~o_if_vld;
    ls_elig     = i_ls_req & ~o_ls_vld;
    grant       = 1'b0;
    grant_owner = OWN_IF;
    if (state == IDLE) begin
      if (ls_elig && (!if_elig || streak < SW'(MAX_LS_STREAK))) begin
        grant       = 1'b1;
        grant_owner = OWN_LS;
      end else if (if_elig) begin
        grant       = 1'b1;
        grant_owner = OWN_IF;
      end
    end
    o_stall_if = i_if_req & ~o_if_vld;
    o_stall_ls = i_ls_req & ~o_ls_vld;
  end

  arb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (grant),
    .i_en     (state != IDLE),
    .o_expire (wd_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      streak      <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      o_if_rdata  <= '0;
      o_if_vld    <= 1'b0;
      o_ls_rdata  <= '0;
      o_ls_vld    <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_if_vld <= 1'b0;
      o_ls_vld <= 1'b0;

      if (!i_if_req || (grant && grant_owner == OWN_IF)) begin
        streak <= '0;
      end else if (grant && if_elig && streak != SW'(MAX_LS_STREAK)) begin
        streak <= streak + 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant && grant_owner == OWN_LS) begin
            state       <= LS_BUSY;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_ls_we;
            o_mem_addr  <= i_ls_addr;
            o_mem_wdata <= i_ls_wdata;
            o_mem_bmask <= i_ls_bmask;
          end else if (grant) begin
            state       <= IF_BUSY;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= '0;
            o_mem_bmask <= '1;
          end
        end
        IF_BUSY: begin
          // A flush wins over a same-cycle ack: the fetch is discarded.
          if (i_if_flush) begin
            if (i_mem_ack || wd_expire) begin
              state     <= IDLE;
              o_mem_req <= 1'b0;
              o_err     <= o_err | (wd_expire & ~i_mem_ack);
            end else begin
              state <= IF_DROP;
            end
          end else if (i_mem_ack) begin
            state      <= IDLE;
            o_mem_req  <= 1'b0;
            o_if_vld   <= 1'b1;
            o_if_rdata <= i_mem_rdata;
          end else if (wd_expire) begin
            state      <= IDLE;
            o_mem_req  <= 1'b0;
            o_err      <= 1'b1;
            o_if_vld   <= 1'b1;
            o_if_rdata <= '0;
          end
        end
        LS_BUSY: begin
          if (i_mem_ack) begin
            state     <= IDLE;
            o_mem_req <= 1'b0;
            o_ls_vld  <= 1'b1;
            if (!o_mem_we) begin
              o_ls_rdata <= i_mem_rdata;
            end
          end else if (wd_expire) begin
            state      <= IDLE;
            o_mem_req  <= 1'b0;
            o_err      <= 1'b1;
            o_ls_vld   <= 1'b1;
            o_ls_rdata <= '0;
          end
        end
        IF_DROP: begin
          if (i_mem_ack) begin
            state     <= IDLE;
            o_mem_req <= 1'b0;
          end else if (wd_expire) begin
            state     <= IDLE;
            o_mem_req <= 1'b0;
            o_err     <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        i_if_flush = 1'b0;
  logic [31:0] o_if_rdata;
  logic        o_if_vld;
  logic        i_ls_req = 1'b0;
  logic        i_ls_we = 1'b0;
  logic [31:0] i_ls_addr = '0;
  logic [31:0] i_ls_wdata = '0;
  logic [3:0]  i_ls_bmask = '0;
  logic [31:0] o_ls_rdata;
  logic        o_ls_vld;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_stall_if;
  logic        o_stall_ls;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .i_if_flush  (i_if_flush),
    .o_if_rdata  (o_if_rdata),
    .o_if_vld    (o_if_vld),
    .i_ls_req    (i_ls_req),
    .i_ls_we     (i_ls_we),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .i_ls_bmask  (i_ls_bmask),
    .o_ls_rdata  (o_ls_rdata),
    .o_ls_vld    (o_ls_vld),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_stall_if  (o_stall_if),
    .o_stall_ls  (o_stall_ls),
    .o_err       (o_err)
  );

  // Memory model: ack after mem_lat extra request cycles (0 = first cycle).
  int mem_lat    = 0;
  int req_cycles = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge i_clk) begin
    #1;
    if (o_mem_req) begin
      i_mem_ack = (req_cycles == mem_lat);
      req_cycles++;
    end else begin
      i_mem_ack  = 1'b0;
      req_cycles = 0;
    end
    i_mem_rdata = i_mem_ack ? mem_data(o_mem_addr) : 32'hA5A5_A5A5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bm;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_vld;
    logic        exp_we;
    logic [3:0]  exp_bm;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  // Starts at the beginning of a cycle; requests, waits for completion,
  // drops the request in the cycle after the vld pulse.
  task automatic apply(input vec_t v, input string tag);
    int          vld_c = -1;
    int          req_c = -1;
    logic [31:0] rd = '0, a_s = '0, wd_s = '0;
    logic        we_s = 1'b0, req_at_vld = 1'b1, stall0 = 1'b0, stall_v = 1'b1;
    logic [3:0]  bm_s = '0;
    mem_lat = v.lat;
    if (v.is_ls) begin
      i_ls_req = 1'b1; i_ls_we = v.we; i_ls_addr = v.addr;
      i_ls_wdata = v.wdata; i_ls_bmask = v.bm;
    end else begin
      i_if_req = 1'b1; i_if_addr = v.addr;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk);
      if (c == 0) stall0 = v.is_ls ? o_stall_ls : o_stall_if;
      if (o_mem_req && req_c < 0) begin
        req_c = c; we_s = o_mem_we; bm_s = o_mem_bmask;
        a_s = o_mem_addr; wd_s = o_mem_wdata;
      end
      if (v.is_ls ? o_ls_vld : o_if_vld) begin
        vld_c = c;
        rd = v.is_ls ? o_ls_rdata : o_if_rdata;
        req_at_vld = o_mem_req;
        stall_v = v.is_ls ? o_stall_ls : o_stall_if;
      end
      @(posedge i_clk); #1;
      if (vld_c >= 0) break;
    end
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_if_req = 1'b0;
    chk_int({tag, "_req_cycle"}, req_c, 1);
    chk_int({tag, "_vld_cycle"}, vld_c, v.exp_vld);
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_mem_we"}, 32'(we_s), 32'(v.exp_we));
    chk({tag, "_mem_bmask"}, 32'(bm_s), 32'(v.exp_bm));
    chk({tag, "_mem_addr"}, a_s, v.addr);
    chk({tag, "_mem_wdata"}, wd_s, v.exp_wdata);
    chk({tag, "_req_at_vld"}, 32'(req_at_vld), 32'd0);
    chk({tag, "_stall_c0"}, 32'(stall0), 32'd1);
    chk({tag, "_stall_at_vld"}, 32'(stall_v), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(o_mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(o_mem_we), 32'd0);
    chk({tag, "_mem_addr"}, o_mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
    chk({tag, "_mem_bmask"}, 32'(o_mem_bmask), 32'd0);
    chk({tag, "_if_rdata"}, o_if_rdata, 32'd0);
    chk({tag, "_if_vld"}, 32'(o_if_vld), 32'd0);
    chk({tag, "_ls_rdata"}, o_ls_rdata, 32'd0);
    chk({tag, "_ls_vld"}, 32'(o_ls_vld), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_stall_if"}, 32'(o_stall_if), 32'd0);
    chk({tag, "_stall_ls"}, 32'(o_stall_ls), 32'd0);
  endtask

  // Both requesters held high; records grant owners (1 = LS) in order.
  // With use_flush, IF is flushed in every LS completion cycle so it stays
  // ineligible exactly when LS is, which lets the LS streak build up.
  task automatic grant_seq(input bit use_flush, input int n,
                           output logic [7:0] log, output int got);
    logic prev = 1'b0;
    int   quiet = 0;
    log = '0; got = 0; mem_lat = 1;
    i_if_req = 1'b1; i_if_addr = 32'h1000_0000;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h2000_0040;
    i_ls_wdata = '0; i_ls_bmask = 4'hF;
    for (int c = 0; c < 200; c++) begin
      i_if_flush = use_flush ? o_ls_vld : 1'b0;
      @(negedge i_clk);
      if (o_mem_req && !prev && got < 8) begin
        log[got] = (o_mem_addr == 32'h2000_0040);
        got++;
      end
      prev = o_mem_req;
      @(posedge i_clk); #1;
      if (got >= n) break;
    end
    i_if_req = 1'b0; i_ls_req = 1'b0; i_if_flush = 1'b0;
    for (int c = 0; c < 50 && quiet < 3; c++) begin
      @(negedge i_clk);
      quiet = o_mem_req ? 0 : quiet + 1;
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        v;
    logic [7:0]  log;
    int          got;
    logic        vld_seen;
    logic [2:0]  reqs;

    vecs[0] = '{is_ls:1'b0, we:1'b0, addr:32'h0000_0100, wdata:32'h0, bm:4'h0, lat:0,
                exp_rdata:32'h0050_0093, exp_vld:2, exp_we:1'b0, exp_bm:4'hF, exp_wdata:32'h0};
    vecs[1] = '{is_ls:1'b1, we:1'b0, addr:32'h0000_3000, wdata:32'h1234_5678, bm:4'hF, lat:2,
                exp_rdata:32'h3000_CFFF, exp_vld:4, exp_we:1'b0, exp_bm:4'hF, exp_wdata:32'h1234_5678};
    vecs[2] = '{is_ls:1'b1, we:1'b1, addr:32'h0000_2000, wdata:32'hDEAD_BEEF, bm:4'b0011, lat:1,
                exp_rdata:32'h3000_CFFF, exp_vld:3, exp_we:1'b1, exp_bm:4'b0011, exp_wdata:32'hDEAD_BEEF};
    vecs[3] = '{is_ls:1'b0, we:1'b0, addr:32'h0000_0204, wdata:32'h0, bm:4'h0, lat:3,
                exp_rdata:32'h0204_FDFB, exp_vld:5, exp_we:1'b0, exp_bm:4'hF, exp_wdata:32'h0};

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk_all_zero("reset");
    @(posedge i_clk); #1;

    for (int i = 0; i < 4; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Fetch flushed while the memory is still working on it.
    mem_lat = 3; vld_seen = 1'b0; reqs = '0;
    i_if_req = 1'b1; i_if_addr = 32'h0000_0180;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin i_if_flush = 1'b1; i_if_req = 1'b0; end
      if (c == 3) i_if_flush = 1'b0;
      @(negedge i_clk);
      if (o_if_vld) vld_seen = 1'b1;
      if (c >= 3 && c <= 5) reqs[c-3] = o_mem_req;
      @(posedge i_clk); #1;
    end
    chk("flush_req_held", 32'(reqs), 32'b011);
    chk("flush_no_vld", 32'(vld_seen), 32'd0);
    chk("flush_rdata_kept", o_if_rdata, 32'h0204_FDFB);
    v = '{is_ls:1'b0, we:1'b0, addr:32'h0000_0200, wdata:32'h0, bm:4'h0, lat:0,
          exp_rdata:32'h0200_FDFF, exp_vld:2, exp_we:1'b0, exp_bm:4'hF, exp_wdata:32'h0};
    apply(v, "after_flush");

    grant_seq(1'b0, 4, log, got);
    chk_int("alt_grants", got, 4);
    chk("alt_order", 32'(log), 32'h05);
    grant_seq(1'b1, 5, log, got);
    chk_int("streak_grants", got, 5);
    chk("streak_order", 32'(log), 32'h0F);

    // Reload a known nonzero LS value, then let a load time out.
    apply(vecs[1], "reload");
    chk("pre_timeout_err", 32'(o_err), 32'd0);
    v = '{is_ls:1'b1, we:1'b0, addr:32'h0000_4000, wdata:32'h0, bm:4'hF, lat:100000,
          exp_rdata:32'h0, exp_vld:256, exp_we:1'b0, exp_bm:4'hF, exp_wdata:32'h0};
    apply(v, "timeout");
    @(negedge i_clk);
    chk("timeout_err_set", 32'(o_err), 32'd1);
    @(posedge i_clk); #1;
    apply(vecs[0], "post_timeout");
    @(negedge i_clk);
    chk("timeout_err_sticky", 32'(o_err), 32'd1);
    @(posedge i_clk); #1;

    // Reset in the middle of a load.
    mem_lat = 20;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h0000_5000; i_ls_bmask = 4'hF;
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("mid_busy_req", 32'(o_mem_req), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_ls_req = 1'b0; i_ls_bmask = 4'h0; i_ls_addr = '0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_all_zero("mid_reset");
    @(posedge i_clk); #1;
    v = '{is_ls:1'b1, we:1'b0, addr:32'h0000_3000, wdata:32'h0, bm:4'hF, lat:0,
          exp_rdata:32'h3000_CFFF, exp_vld:2, exp_we:1'b0, exp_bm:4'hF, exp_wdata:32'h0};
    apply(v, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
